// File: rtl/rv32_lsu_pkg.sv
// Shared types for the RV32I load/store unit:
// funct3 codes, error codes, FSM states.
package rv32_lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_MISALIGN = 2'd1,
    ERR_RANGE    = 2'd2,
    ERR_FUNCT3   = 2'd3
  } lsu_err_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_LOAD_WAIT,
    ST_RESP
  } lsu_state_e;

  typedef struct packed {
    logic       we;
    logic [2:0] funct3;
    logic [1:0] off;
  } lsu_req_t;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering, load extraction
// and fault classification for the LSU.
module lsu_align
  import rv32_lsu_pkg::*;
#(
  parameter int          ADDR_W    = 12,
  parameter logic [31:0] BASE_ADDR = 32'h0
) (
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [3:0]  st_be,
  output logic [31:0] st_data,
  output logic [1:0]  err,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_off,
  input  logic [31:0] rdata,
  output logic [31:0] ld_data
);

  localparam logic [32:0] SPAN = 33'd1 << (ADDR_W + 2);

  logic [31:0] rel;
  logic        f3_bad;
  logic        mis;
  logic        rng;
  logic [31:0] sh;
  logic [7:0]  b;
  logic [15:0] h;

  assign rel = addr - BASE_ADDR;

  assign f3_bad = we ? (funct3 > F3_W)
                     : (funct3 == 3'd3 ||
                        funct3[2:1] == 2'b11);

  assign mis = (funct3[1:0] == 2'b01 && addr[0]) ||
               (funct3[1:0] == 2'b10 &&
                addr[1:0] != 2'b00);

  assign rng = (addr < BASE_ADDR) ||
               ({1'b0, rel} >= SPAN);

  always_comb begin
    err = ERR_NONE;
    if (f3_bad)   err = ERR_FUNCT3;
    else if (mis) err = ERR_MISALIGN;
    else if (rng) err = ERR_RANGE;
  end

  always_comb begin
    st_be   = 4'b1111;
    st_data = wdata;
    unique case (funct3[1:0])
      2'b00: begin
        st_be   = 4'b0001 << addr[1:0];
        st_data = {4{wdata[7:0]}};
      end
      2'b01: begin
        st_be   = addr[1] ? 4'b1100 : 4'b0011;
        st_data = {2{wdata[15:0]}};
      end
      default: begin
        st_be   = 4'b1111;
        st_data = wdata;
      end
    endcase
  end

  assign sh = rdata >> {ld_off, 3'b000};
  assign b  = sh[7:0];
  assign h  = ld_off[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    ld_data = rdata;
    unique case (ld_funct3)
      F3_B:    ld_data = {{24{b[7]}}, b};
      F3_BU:   ld_data = {24'h0, b};
      F3_H:    ld_data = {{16{h[15]}}, h};
      F3_HU:   ld_data = {16'h0, h};
      default: ld_data = rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: request FSM driving a
// word-addressed, byte-enabled synchronous memory.
module load_store_unit
  import rv32_lsu_pkg::*;
#(
  parameter int          ADDR_W    = 12,
  parameter logic [31:0] BASE_ADDR = 32'h0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic [1:0]        rsp_err,
  output logic              mem_en,
  output logic [3:0]        mem_we,
  output logic [ADDR_W-1:0] mem_adr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  lsu_state_e        state;
  lsu_req_t          lat;
  logic [3:0]        st_be;
  logic [31:0]       st_data;
  logic [31:0]       ld_data;
  logic [1:0]        err;
  logic [ADDR_W-1:0] adr_n;
  logic              acc;

  assign req_ready = rst_n && (state == ST_IDLE);
  assign acc       = req_valid && req_ready;
  assign adr_n     = ADDR_W'((req_addr - BASE_ADDR) >> 2);

  lsu_align #(
    .ADDR_W    (ADDR_W),
    .BASE_ADDR (BASE_ADDR)
  ) u_align (
    .we        (req_we),
    .funct3    (req_funct3),
    .addr      (req_addr),
    .wdata     (req_wdata),
    .st_be     (st_be),
    .st_data   (st_data),
    .err       (err),
    .ld_funct3 (lat.funct3),
    .ld_off    (lat.off),
    .rdata     (mem_rdata),
    .ld_data   (ld_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      lat       <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= ERR_NONE;
      mem_en    <= 1'b0;
      mem_we    <= '0;
      mem_adr   <= '0;
      mem_wdata <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (acc) begin
            lat <= '{req_we, req_funct3,
                     req_addr[1:0]};
            if (err != ERR_NONE) begin
              state     <= ST_RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= err;
              rsp_rdata <= '0;
            end else begin
              state   <= ST_ACCESS;
              mem_en  <= 1'b1;
              mem_adr <= adr_n;
              mem_we  <= req_we ? st_be : 4'b0000;
              if (req_we) mem_wdata <= st_data;
            end
          end
        end
        ST_ACCESS: begin
          mem_en <= 1'b0;
          mem_we <= '0;
          if (lat.we) begin
            state     <= ST_RESP;
            rsp_valid <= 1'b1;
            rsp_err   <= ERR_NONE;
            rsp_rdata <= '0;
          end else begin
            state <= ST_LOAD_WAIT;
          end
        end
        ST_LOAD_WAIT: begin
          state     <= ST_RESP;
          rsp_valid <= 1'b1;
          rsp_err   <= ERR_NONE;
          rsp_rdata <= ld_data;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            state     <= ST_IDLE;
            rsp_valid <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized bench for load_store_unit against a
// byte-array reference model and a behavioural memory.
module tb_load_store_unit;

  localparam int AW   = 12;
  localparam int SPAN = 4 << AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [2:0]    req_funct3 = '0;
  logic [31:0]   req_addr = '0;
  logic [31:0]   req_wdata = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [31:0]   rsp_rdata;
  logic [1:0]    rsp_err;
  logic          mem_en;
  logic [3:0]    mem_we;
  logic [AW-1:0] mem_adr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata = '0;

  logic [31:0] mem_arr [1<<AW] = '{default: 32'h0};
  logic [7:0]  ref_mem [SPAN];

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  load_store_unit #(
    .ADDR_W    (AW),
    .BASE_ADDR (32'h0)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_adr    (mem_adr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  always @(posedge clk) begin
    if (mem_en) begin
      for (int i = 0; i < 4; i++)
        if (mem_we[i])
          mem_arr[mem_adr][8*i +: 8] <= mem_wdata[8*i +: 8];
      mem_rdata <= mem_arr[mem_adr];
    end
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] ref_err(
      input logic we, input logic [2:0] f3,
      input logic [31:0] a);
    int n;
    if (we ? (f3 > 2) : (f3 == 3 || f3 == 6 || f3 == 7))
      return 2'd3;
    n = 1 << f3[1:0];
    if ((a & (32'(n) - 1)) != 0) return 2'd1;
    if (longint'(a) >= longint'(SPAN)) return 2'd2;
    return 2'd0;
  endfunction

  task automatic xact(input logic we, input logic [2:0] f3,
                      input logic [31:0] a,
                      input logic [31:0] wd,
                      input int stall);
    logic [1:0]  e;
    logic [3:0]  exp_be;
    logic [31:0] exp_wd, exp_rd;
    int n, off, lat_exp, lat, en_cnt, w;
    bit seen;
    e = ref_err(we, f3, a);
    n = 1 << f3[1:0];
    off = int'(a[1:0]);
    exp_be = '0;
    exp_wd = '0;
    exp_rd = '0;
    if (e == 0 && we) begin
      for (int i = 0; i < 4; i++) begin
        if (i >= off && i < off + n) exp_be[i] = 1'b1;
        exp_wd[8*i +: 8] = wd[8*(i % n) +: 8];
      end
      for (int k = 0; k < n; k++)
        ref_mem[int'(a) + k] = wd[8*k +: 8];
    end
    if (e == 0 && !we) begin
      for (int k = 0; k < n; k++)
        exp_rd |= 32'(ref_mem[int'(a) + k]) << (8*k);
      if (!f3[2] && n < 4 && exp_rd[8*n-1])
        exp_rd |= ~((32'h1 << (8*n)) - 1);
    end
    lat_exp = (e != 0) ? 1 : (we ? 2 : 3);

    @(negedge clk);
    w = 0;
    while (!req_ready && w < 10) begin
      @(negedge clk);
      w++;
    end
    check("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_we = we;
    req_funct3 = f3;
    req_addr = a;
    req_wdata = wd;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_we = 1'($urandom);
    req_addr = $urandom;
    req_wdata = $urandom;
    lat = 0;
    en_cnt = 0;
    seen = 0;
    for (int c = 1; c <= 8 && !seen; c++) begin
      @(negedge clk);
      if (mem_en) begin
        en_cnt++;
        check("mem_adr", 32'(mem_adr), a >> 2);
        check("mem_we", 32'(mem_we), 32'(exp_be));
        if (we) check("mem_wdata", mem_wdata, exp_wd);
      end
      if (rsp_valid) begin
        seen = 1;
        lat = c;
      end
    end
    check("latency", lat, lat_exp);
    check("mem_en_cnt", en_cnt, 32'(e == 0));
    check("rsp_err", 32'(rsp_err), 32'(e));
    check("rsp_rdata", rsp_rdata, exp_rd);
    if (seen) begin
      for (int s = 0; s < stall; s++) begin
        @(negedge clk);
        check("hold_valid", 32'(rsp_valid), 32'd1);
        check("hold_rdata", rsp_rdata, exp_rd);
        check("hold_err", 32'(rsp_err), 32'(e));
        check("busy_ready", 32'(req_ready), 32'd0);
      end
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    @(negedge clk);
    check("post_ready", 32'(req_ready), 32'd1);
    check("post_valid", 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic        we;
    logic [2:0]  f3;
    logic [31:0] a;
    int          n, r;
    logic [2:0]  ldf3 [5];
    ldf3 = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    for (int i = 0; i < SPAN; i++) ref_mem[i] = 8'h0;

    repeat (2) @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    check("rst_mem_en", 32'(mem_en), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_adr", 32'(mem_adr), 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    rst_n = 1'b1;
    #1;
    check("rel_req_ready", 32'(req_ready), 32'd1);

    xact(1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 0);
    xact(1'b1, 3'd0, 32'h13, 32'h000000A5, 0);
    xact(1'b0, 3'd0, 32'h13, 32'h0, 0);
    xact(1'b0, 3'd4, 32'h13, 32'h0, 0);
    xact(1'b1, 3'd1, 32'h22, 32'h00008001, 0);
    xact(1'b0, 3'd1, 32'h22, 32'h0, 0);
    xact(1'b0, 3'd5, 32'h22, 32'h0, 0);
    xact(1'b0, 3'd2, 32'h06, 32'h0, 0);
    xact(1'b0, 3'd2, 32'h4000, 32'h0, 0);
    xact(1'b0, 3'd3, 32'h05, 32'h0, 0);
    xact(1'b1, 3'd2, 32'hFFFFFFF0, 32'h1, 1);
    xact(1'b0, 3'd2, 32'h10, 32'h0, 5);

    xact(1'b1, 3'd2, 32'h20, 32'h11223344, 0);
    @(negedge clk);
    req_valid = 1'b1;
    req_we = 1'b1;
    req_funct3 = 3'd2;
    req_addr = 32'h20;
    req_wdata = 32'hCAFEF00D;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    check("rst_pre_en", 32'(mem_en), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_en_drop", 32'(mem_en), 32'd0);
    check("rst_we_drop", 32'(mem_we), 32'd0);
    check("rst_no_rsp", 32'(rsp_valid), 32'd0);
    check("rst_busy", 32'(req_ready), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rel2_ready", 32'(req_ready), 32'd1);
    repeat (3) begin
      @(negedge clk);
      check("rel2_no_rsp", 32'(rsp_valid), 32'd0);
    end
    xact(1'b0, 3'd2, 32'h20, 32'h0, 0);

    repeat (80) begin
      we = 1'($urandom);
      if ($urandom % 5 != 0)
        f3 = we ? 3'($urandom % 3) : ldf3[$urandom % 5];
      else
        f3 = 3'($urandom);
      n = 1 << f3[1:0];
      r = int'($urandom % 10);
      if (r < 8) begin
        a = $urandom % 64;
        if ($urandom % 4 != 0) a = a & ~(32'(n) - 1);
      end else if (r == 8) begin
        a = 32'h4000 + ($urandom % 32);
      end else begin
        a = $urandom;
      end
      xact(we, f3, a, $urandom, int'($urandom % 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Initiator side of the data memory port.
- Accepts one RV32I load/store request at a time from the core over a valid/ready handshake.
- Drives the memory's word-addressed, byte-enabled synchronous port, with read data registered one clock after EN.
- Returns sign/zero-extended load data or store completion through a valid/ready response channel.
- Performs alignment and range checks and reports faults without touching memory.

Parameters:
- ADDR_W, 12: memory word-address width; memory spans 4*2^ADDR_W bytes.
- BASE_ADDR, 32'h0000_0000: byte address of memory word 0; must be aligned to 4*2^ADDR_W.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous reset, active-low
- req_valid  in  1  core request valid
- req_ready  out  1  unit can accept request
- req_we  in  1  1=store, 0=load
- req_funct3  in  3  RV32I funct3 (LB/LH/LW/LBU/LHU or SB/SH/SW)
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned
- rsp_valid  out  1  response valid
- rsp_ready  in  1  core accepts response
- rsp_rdata  out  32  extended load data; 0 for stores and faults
- rsp_err  out  2  0=OK, 1=misaligned, 2=out-of-range, 3=illegal funct3
- mem_en  out  1  memory enable
- mem_we  out  4  byte write enables, bit i = lane i (bits 8i+7:8i)
- mem_adr  out  ADDR_W  word address
- mem_wdata  out  32  lane-steered store data
- mem_rdata  in  32  memory read data, valid the cycle after an enabled access

Behaviour:
- Clocking and reset: single clock; asynchronous active-low reset.
- Reset values, held while rst_n=0:
  - state=IDLE; req_ready=0.
  - rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - mem_en=0, mem_we=0, mem_adr=0, mem_wdata=0.
- req_ready=1 only in IDLE with rst_n=1.
- All mem_* outputs are registered from the latched request.
- FSM states: IDLE, ACCESS, LOAD_WAIT, RESP.
  - IDLE: on req_valid&&req_ready, latch request and compute error.
    - err!=0 -> RESP.
    - else -> ACCESS.
  - ACCESS (exactly 1 cycle):
    - mem_en=1; mem_adr=(addr-BASE_ADDR)[ADDR_W+1:2].
    - Store: mem_we/mem_wdata driven -> RESP.
    - Load: mem_we=0 -> LOAD_WAIT.
  - LOAD_WAIT (1 cycle): mem_en=0; capture extracted mem_rdata into rsp_rdata -> RESP.
  - RESP: rsp_valid=1; hold rsp_rdata and rsp_err stable until rsp_ready; on rsp_valid&&rsp_ready -> IDLE.
    - No new request is accepted in the handshake cycle; next accept is earliest the following cycle.
- Latency, accept edge = cycle 0:
  - Fault: rsp_valid in cycle 1.
  - Store: mem_en in cycle 1, rsp_valid in cycle 2.
  - Load: mem_en in cycle 1, rsp_valid in cycle 3.
- Error priority: illegal funct3 > misaligned > out-of-range.
  - Illegal funct3: loads 3, 6, 7; stores 3–7.
  - Misaligned: halfword with addr[0]=1; word with addr[1:0]!=0.
  - Out-of-range: addr < BASE_ADDR or addr-BASE_ADDR >= 4*2^ADDR_W.
  - On any fault: mem_en stays 0 and no memory write occurs.
- Store lane steering, off = addr[1:0]:
  - SB: mem_wdata = byte replicated x4; mem_we = 4'b0001<<off.
  - SH: mem_wdata = halfword replicated x2; mem_we = 4'b0011 (off=0) or 4'b1100 (off=2).
  - SW: mem_we = 4'b1111; mem_wdata = req_wdata.
- Load extraction from mem_rdata:
  - LB/LBU: lane off, sign-/zero-extended to 32 bits.
  - LH/LHU: bits [15:0] (off=0) or [31:16] (off=2), sign-/zero-extended.
  - LW: full word.
- rsp_rdata=0 for stores and faults.
- Inputs req_* are ignored outside IDLE; rsp_ready is ignored outside RESP.
- Reset mid-operation: returns to IDLE immediately and mem_en drops asynchronously.
  - Reset before the ACCESS rising edge: no memory write.
  - Pending response is discarded; no response is produced after reset.

Decomposition:
- Package rv32_lsu_pkg:
  - funct3 localparams F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - lsu_err_e enum: ERR_NONE, ERR_MISALIGN, ERR_RANGE, ERR_FUNCT3.
  - lsu_state_e enum.
- Sub-module lsu_align (combinational):
  - Store side: funct3/off/wdata -> mem_we/mem_wdata.
  - Load side: funct3/off/rdata -> extended result.
  - Error classification.
- Top module holds the FSM and registers.

Test Plan:
- SW addr 0x10, wdata 0xDEADBEEF -> cycle 1: mem_en=1, mem_adr=4, mem_we=1111, mem_wdata=0xDEADBEEF; cycle 2: rsp_valid=1, rsp_err=0.
- SB 0x13, wdata 0x000000A5 -> mem_we=1000, mem_wdata=0xA5A5A5A5; then LB 0x13 -> rsp_rdata=0xFFFFFFA5 in cycle 3; LBU 0x13 -> 0x000000A5.
- SH 0x22, wdata 0x8001 -> mem_we=1100, mem_wdata=0x80018001; LH 0x22 -> 0xFFFF8001; LHU 0x22 -> 0x00008001.
- LW 0x06 -> rsp_err=1 in cycle 1, mem_en never 1.
  - LW 0x4000 (ADDR_W=12) -> rsp_err=2.
  - Load funct3=3 at misaligned 0x05 -> rsp_err=3 (priority).
- Backpressure: rsp_ready=0 for 5 cycles on LW response -> rsp_valid, rsp_rdata stable, req_ready=0; after handshake req_ready=1 next cycle.
- Assert rst_n=0 during ACCESS of SW to word 8 -> mem_en drops immediately; after release, LW word 8 returns the prior value; req_ready=1, rsp_valid=0.
